// File: rtl/cu_seq_pkg.sv
// Shared constants for the sequencer: opcode classes, NOP codes,
// data-bus source codes and write-enable bit positions.
package cu_seq_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_MOVE,
        CLS_ALU,
        CLS_JMP,
        CLS_JNZ
    } instr_class_e;

    // Opcode prefixes
    localparam logic       PFX_LOAD = 1'b0;     // ir[7]
    localparam logic [1:0] PFX_MOVE = 2'b10;    // ir[7:6]
    localparam logic [2:0] PFX_ALU  = 3'b110;   // ir[7:5]
    localparam logic [3:0] PFX_JMP  = 4'b1110;  // ir[7:4]
    localparam logic [3:0] PFX_JNZ  = 4'b1111;  // ir[7:4]

    // NOP codes; C8 is also the flush/reset filler
    localparam logic [7:0] NOP_C8 = 8'hC8;
    localparam logic [7:0] NOP_CF = 8'hCF;
    localparam logic [7:0] NOP_D8 = 8'hD8;
    localparam logic [7:0] NOP_DF = 8'hDF;

    // Data-bus source codes beyond the 0..7 register sources
    localparam logic [3:0] SRC_IMM   = 4'd8;
    localparam logic [3:0] SRC_IPINS = 4'd9;
    localparam logic [3:0] SRC_NONE  = 4'd10;

    // reg_en bit positions
    localparam int REN_X0 = 0;
    localparam int REN_X1 = 1;
    localparam int REN_Y0 = 2;
    localparam int REN_Y1 = 3;
    localparam int REN_R  = 4;
    localparam int REN_M  = 5;
    localparam int REN_I  = 6;
    localparam int REN_DM = 7;
    localparam int REN_O  = 8;

    // Destination / source register codes with special handling
    localparam logic [2:0] DST_I  = 3'd6;
    localparam logic [2:0] DST_DM = 3'd7;

    function automatic instr_class_e classify(input logic [7:0] ir);
        if (ir[7] == PFX_LOAD)          return CLS_LOAD;
        else if (ir[7:6] == PFX_MOVE)   return CLS_MOVE;
        else if (ir[7:5] == PFX_ALU)    return CLS_ALU;
        else if (ir[7:4] == PFX_JMP)    return CLS_JMP;
        else                            return CLS_JNZ;
    endfunction

    // Destination code 4 is o_reg, which lives at the top of reg_en
    function automatic logic [8:0] dest_onehot(input logic [2:0] dst);
        logic [8:0] oh;
        oh = '0;
        unique case (dst)
            3'd0:    oh[REN_X0] = 1'b1;
            3'd1:    oh[REN_X1] = 1'b1;
            3'd2:    oh[REN_Y0] = 1'b1;
            3'd3:    oh[REN_Y1] = 1'b1;
            3'd4:    oh[REN_O]  = 1'b1;
            3'd5:    oh[REN_M]  = 1'b1;
            3'd6:    oh[REN_I]  = 1'b1;
            default: oh[REN_DM] = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Program-memory and control bundle between the sequencer and the
// computational unit / program ROM.
interface cu_sequencer_if;
    logic [7:0] pm_data;
    logic       zero_flag;
    logic [7:0] pm_addr;
    logic [7:0] ir;
    logic [3:0] nibble_ir;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic       NOPC8;
    logic       NOPCF;
    logic       NOPD8;
    logic       NOPDF;
    logic       jmp_taken;

    // Sequencer side: drives the program address and all controls
    modport master (
        input  pm_data, zero_flag,
        output pm_addr, ir, nibble_ir, source_sel, reg_en,
               i_sel, x_sel, y_sel, NOPC8, NOPCF, NOPD8, NOPDF, jmp_taken
    );

    // Datapath / ROM side
    modport slave (
        output pm_data, zero_flag,
        input  pm_addr, ir, nibble_ir, source_sel, reg_en,
               i_sel, x_sel, y_sel, NOPC8, NOPCF, NOPD8, NOPDF, jmp_taken
    );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode from ir (plus zero_flag for
// the conditional jump).
module instr_decoder
    import cu_seq_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       zero_flag,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       nop_c8,
    output logic       nop_cf,
    output logic       nop_d8,
    output logic       nop_df,
    output logic       jmp_taken
);
    instr_class_e cls;
    logic [2:0]   dst;
    logic [2:0]   src;

    assign cls    = classify(ir);
    assign nop_c8 = (ir == NOP_C8);
    assign nop_cf = (ir == NOP_CF);
    assign nop_d8 = (ir == NOP_D8);
    assign nop_df = (ir == NOP_DF);

    // Decode the current instruction into bus source, write enables and selects
    always_comb begin
        source_sel = SRC_NONE;
        reg_en     = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        jmp_taken  = 1'b0;
        dst        = ir[5:3];
        src        = ir[2:0];
        case (cls)
            CLS_LOAD: begin
                dst        = ir[6:4];
                source_sel = SRC_IMM;
                reg_en     = dest_onehot(dst);
                if (dst == DST_DM) begin
                    reg_en[REN_I] = 1'b1;
                    i_sel         = 1'b1;
                end
            end
            CLS_MOVE: begin
                source_sel = (dst == src) ? SRC_IPINS : {1'b0, src};
                reg_en     = dest_onehot(dst);
                // Any dm access post-increments i, unless i itself is the target
                if ((dst == DST_DM || src == DST_DM) && dst != DST_I) begin
                    reg_en[REN_I] = 1'b1;
                    i_sel         = 1'b1;
                end
            end
            CLS_ALU: begin
                x_sel         = ir[4];
                y_sel         = ir[3];
                reg_en[REN_R] = ~(nop_c8 | nop_cf | nop_d8 | nop_df);
            end
            CLS_JMP: jmp_taken = 1'b1;
            CLS_JNZ: jmp_taken = ~zero_flag;
            default: jmp_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_sequencer.sv
// Program sequencer: pc and ir registers, fetch, and jump/flush control.
module cu_sequencer
    import cu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          sync_reset,
    cu_sequencer_if.master bus
);
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       jmp_taken;

    instr_decoder u_dec (
        .ir         (ir_q),
        .zero_flag  (bus.zero_flag),
        .source_sel (bus.source_sel),
        .reg_en     (bus.reg_en),
        .i_sel      (bus.i_sel),
        .x_sel      (bus.x_sel),
        .y_sel      (bus.y_sel),
        .nop_c8     (bus.NOPC8),
        .nop_cf     (bus.NOPCF),
        .nop_d8     (bus.NOPD8),
        .nop_df     (bus.NOPDF),
        .jmp_taken  (jmp_taken)
    );

    assign bus.pm_addr   = pc_q;
    assign bus.ir        = ir_q;
    assign bus.nibble_ir = ir_q[3:0];
    assign bus.jmp_taken = jmp_taken;

    // Next fetch: sequential pc, or jump within the page of pc with the
    // already-prefetched word replaced by a NOP
    always_comb begin
        pc_d = pc_q + 8'd1;
        ir_d = bus.pm_data;
        if (jmp_taken) begin
            pc_d = {pc_q[7:4], ir_q[3:0]};
            ir_d = NOP_C8;
        end
    end

    // pc / ir registers; reset wins over a pending jump
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q <= 8'h00;
            ir_q <= NOP_C8;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios plus a
// randomized run against a behavioural model of fetch/decode.
module tb_cu_sequencer;

    typedef struct packed {
        logic [3:0] src;
        logic [8:0] en;
        logic       isel;
        logic       xsel;
        logic       ysel;
        logic       jt;
        logic [3:0] nops;
    } exp_t;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic [7:0] rom [256];
    int         checks = 0;
    int         errors = 0;

    cu_sequencer_if bus ();

    cu_sequencer dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign bus.pm_data = rom[bus.pm_addr];

    // Expected controls for an instruction byte, from the instruction-set rules
    function automatic exp_t expect_dec(input logic [7:0] i, input logic zf);
        int   dmap [8];
        int   v, d, s;
        exp_t e;
        dmap = '{0, 1, 2, 3, 8, 5, 6, 7};
        v = int'(i);
        e = '0;
        e.src = 4'd10;
        if (v < 128) begin
            d = (v / 16) % 8;
            e.src = 4'd8;
            e.en[dmap[d]] = 1'b1;
            if (d == 7) begin
                e.en[6] = 1'b1;
                e.isel  = 1'b1;
            end
        end else if (v < 192) begin
            d = (v / 8) % 8;
            s = v % 8;
            e.src = (d == s) ? 4'd9 : 4'(s);
            e.en[dmap[d]] = 1'b1;
            if ((d == 7 || s == 7) && d != 6) begin
                e.en[6] = 1'b1;
                e.isel  = 1'b1;
            end
        end else if (v < 224) begin
            e.xsel = ((v / 16) % 2) != 0;
            e.ysel = ((v / 8) % 2) != 0;
            if (!(v == 200 || v == 207 || v == 216 || v == 223)) e.en[4] = 1'b1;
        end else if (v < 240) begin
            e.jt = 1'b1;
        end else begin
            e.jt = !zf;
        end
        e.nops = {v == 223, v == 216, v == 207, v == 200};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        repeat (2) tick();
        sync_reset = 1'b0;
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int a = 0; a < 256; a++) rom[a] = val;
    endtask

    task automatic test_reset();
        fill_rom(8'h11);
        bus.zero_flag = 1'b1;
        do_reset();
        checks++; if (bus.ir !== 8'hC8) begin errors++; $display("FAIL reset_ir: got %h want c8", bus.ir); end
        checks++; if (bus.pm_addr !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", bus.pm_addr); end
        checks++; if (bus.reg_en !== 9'h000) begin errors++; $display("FAIL reset_reg_en: got %h want 000", bus.reg_en); end
        checks++; if (bus.NOPC8 !== 1'b1) begin errors++; $display("FAIL reset_nopc8: got %b want 1", bus.NOPC8); end
        checks++; if (bus.jmp_taken !== 1'b0) begin errors++; $display("FAIL reset_jmp: got %b want 0", bus.jmp_taken); end
        tick();
        checks++; if (bus.pm_addr !== 8'h01) begin errors++; $display("FAIL reset_pc1: got %h want 01", bus.pm_addr); end
        checks++; if (bus.ir !== 8'h11) begin errors++; $display("FAIL reset_first_ir: got %h want 11", bus.ir); end
        tick();
        checks++; if (bus.pm_addr !== 8'h02) begin errors++; $display("FAIL reset_pc2: got %h want 02", bus.pm_addr); end
    endtask

    task automatic test_decode();
        fill_rom(8'hC8);
        rom[0] = 8'h53; rom[1] = 8'hBC; rom[2] = 8'h89; rom[3] = 8'hD2; rom[4] = 8'hCF;
        bus.zero_flag = 1'b0;
        do_reset();
        tick();
        checks++; if (bus.source_sel !== 4'd8) begin errors++; $display("FAIL load_src: got %0d want 8", bus.source_sel); end
        checks++; if (bus.reg_en !== 9'h020) begin errors++; $display("FAIL load_en: got %h want 020", bus.reg_en); end
        checks++; if (bus.nibble_ir !== 4'h3) begin errors++; $display("FAIL load_nibble: got %h want 3", bus.nibble_ir); end
        tick();
        checks++; if (bus.source_sel !== 4'd4) begin errors++; $display("FAIL move_src: got %0d want 4", bus.source_sel); end
        checks++; if (bus.reg_en !== 9'h0C0) begin errors++; $display("FAIL move_en: got %h want 0c0", bus.reg_en); end
        checks++; if (bus.i_sel !== 1'b1) begin errors++; $display("FAIL move_isel: got %b want 1", bus.i_sel); end
        tick();
        checks++; if (bus.source_sel !== 4'd9) begin errors++; $display("FAIL moveeq_src: got %0d want 9", bus.source_sel); end
        checks++; if (bus.reg_en !== 9'h002) begin errors++; $display("FAIL moveeq_en: got %h want 002", bus.reg_en); end
        tick();
        checks++; if ({bus.x_sel, bus.y_sel} !== 2'b10) begin errors++; $display("FAIL alu_sel: got %b want 10", {bus.x_sel, bus.y_sel}); end
        checks++; if (bus.reg_en !== 9'h010) begin errors++; $display("FAIL alu_en: got %h want 010", bus.reg_en); end
        tick();
        checks++; if (bus.reg_en !== 9'h000) begin errors++; $display("FAIL nop_en: got %h want 000", bus.reg_en); end
        checks++; if (bus.NOPCF !== 1'b1) begin errors++; $display("FAIL nop_flag: got %b want 1", bus.NOPCF); end
    endtask

    task automatic test_jump();
        fill_rom(8'hC8);
        rom[8'h2F] = 8'hF7;
        rom[8'h30] = 8'h53;
        bus.zero_flag = 1'b0;
        do_reset();
        repeat (8'h30) tick();
        checks++; if (bus.ir !== 8'hF7) begin errors++; $display("FAIL jnz_fetch: got %h want f7", bus.ir); end
        checks++; if (bus.jmp_taken !== 1'b1) begin errors++; $display("FAIL jnz_taken: got %b want 1", bus.jmp_taken); end
        tick();
        checks++; if (bus.pm_addr !== 8'h37) begin errors++; $display("FAIL jnz_target: got %h want 37", bus.pm_addr); end
        checks++; if (bus.ir !== 8'hC8) begin errors++; $display("FAIL jnz_flush: got %h want c8", bus.ir); end
        checks++; if (bus.jmp_taken !== 1'b0) begin errors++; $display("FAIL jnz_one_cycle: got %b want 0", bus.jmp_taken); end
        bus.zero_flag = 1'b1;
        do_reset();
        repeat (8'h30) tick();
        checks++; if (bus.jmp_taken !== 1'b0) begin errors++; $display("FAIL jnz_not_taken: got %b want 0", bus.jmp_taken); end
        tick();
        checks++; if (bus.pm_addr !== 8'h31) begin errors++; $display("FAIL jnz_fall_pc: got %h want 31", bus.pm_addr); end
        checks++; if (bus.ir !== 8'h53) begin errors++; $display("FAIL jnz_no_flush: got %h want 53", bus.ir); end
    endtask

    task automatic test_reset_vs_jump();
        fill_rom(8'hC8);
        rom[0] = 8'hE5;
        bus.zero_flag = 1'b1;
        do_reset();
        tick();
        checks++; if (bus.jmp_taken !== 1'b1) begin errors++; $display("FAIL jmp_taken: got %b want 1", bus.jmp_taken); end
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        checks++; if (bus.pm_addr !== 8'h00) begin errors++; $display("FAIL rst_over_jmp_pc: got %h want 00", bus.pm_addr); end
        checks++; if (bus.ir !== 8'hC8) begin errors++; $display("FAIL rst_over_jmp_ir: got %h want c8", bus.ir); end
        tick();
        tick();
        checks++; if (bus.pm_addr !== 8'h05) begin errors++; $display("FAIL jmp_target: got %h want 05", bus.pm_addr); end
    endtask

    task automatic test_random();
        logic [7:0] m_pc, m_ir;
        exp_t       e;
        logic       zf, rst;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        bus.zero_flag = 1'b0;
        do_reset();
        m_pc = 8'h00;
        m_ir = 8'hC8;
        for (int n = 0; n < 3000; n++) begin
            zf  = 1'($urandom);
            rst = ($urandom_range(0, 31) == 0);
            bus.zero_flag = zf;
            sync_reset    = rst;
            #1;
            e = expect_dec(m_ir, zf);
            checks++; if (bus.pm_addr !== m_pc) begin errors++; $display("FAIL rnd_pc: got %h want %h", bus.pm_addr, m_pc); end
            checks++; if (bus.ir !== m_ir) begin errors++; $display("FAIL rnd_ir: got %h want %h", bus.ir, m_ir); end
            checks++; if (bus.nibble_ir !== m_ir[3:0]) begin errors++; $display("FAIL rnd_nibble: got %h want %h", bus.nibble_ir, m_ir[3:0]); end
            checks++; if (bus.source_sel !== e.src) begin errors++; $display("FAIL rnd_src ir=%h: got %0d want %0d", m_ir, bus.source_sel, e.src); end
            checks++; if (bus.reg_en !== e.en) begin errors++; $display("FAIL rnd_en ir=%h: got %h want %h", m_ir, bus.reg_en, e.en); end
            checks++; if ({bus.i_sel, bus.x_sel, bus.y_sel} !== {e.isel, e.xsel, e.ysel}) begin
                errors++; $display("FAIL rnd_sel ir=%h: got %b want %b", m_ir, {bus.i_sel, bus.x_sel, bus.y_sel}, {e.isel, e.xsel, e.ysel});
            end
            checks++; if (bus.jmp_taken !== e.jt) begin errors++; $display("FAIL rnd_jmp ir=%h: got %b want %b", m_ir, bus.jmp_taken, e.jt); end
            checks++; if ({bus.NOPDF, bus.NOPD8, bus.NOPCF, bus.NOPC8} !== e.nops) begin
                errors++; $display("FAIL rnd_nops ir=%h: got %b want %b", m_ir, {bus.NOPDF, bus.NOPD8, bus.NOPCF, bus.NOPC8}, e.nops);
            end
            @(posedge clk);
            if (rst) begin
                m_pc = 8'h00;
                m_ir = 8'hC8;
            end else if (e.jt) begin
                m_pc = {m_pc[7:4], m_ir[3:0]};
                m_ir = 8'hC8;
            end else begin
                m_ir = rom[m_pc];
                m_pc = m_pc + 8'd1;
            end
            #1;
        end
        sync_reset = 1'b0;
    endtask

    initial begin
        sync_reset    = 1'b1;
        bus.zero_flag = 1'b0;
        test_reset();
        test_decode();
        test_jump();
        test_reset_vs_jump();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
